pong_game_ctrl: RTL and testbench

Game-flow controller sitting directly downstream of the ball block. It consumes the ball position and paddle position each frame to detect paddle hits and misses past the right edge. It keeps a 2-digit BCD score and a lives counter, and runs the IDLE/PLAY/MISS/OVER state machine. It drives ball_rstn, which holds the ball block in reset (re-centred) while the game is idle, during the post-miss pause, and after game over.

---
 rtl/pong_pkg.sv | 19 +
 rtl/pong_game_ctrl_bcd2_sat_counter.sv | 33 +++
 rtl/pong_game_ctrl.sv | 155 +++++++++++++++
 tb/tb_pong_game_ctrl.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/pong_pkg.sv
// Shared pong constants: screen size, ball/paddle geometry and the game
// state encoding. Also used by the ball, paddle and renderer blocks.
package pong_pkg;

  localparam int MAX_X     = 640;
  localparam int MAX_Y     = 480;
  localparam int BALL_SIZE = 10;
  localparam int PADDLE_W  = 10;
  localparam int PADDLE_H  = 100;

  // Encoding is visible on game_state: 0=IDLE 1=PLAY 2=MISS 3=OVER
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_MISS = 2'd2,
    ST_OVER = 2'd3
  } state_e;

endpackage

// File: rtl/pong_game_ctrl_bcd2_sat_counter.sv
// Two-digit BCD counter, 00..99, saturating at 99.
//   clk, rstn : clock, async active-low reset (clears to 00)
//   clr       : synchronous clear to 00, wins over inc
//   inc       : count up by one (no effect at 99)
//   q         : {tens, ones} BCD value, registered
module bcd2_sat_counter (
  input  logic       clk,
  input  logic       rstn,
  input  logic       clr,
  input  logic       inc,
  output logic [7:0] q
);

  logic [7:0] q_q, q_d;

  always_comb begin
    q_d = q_q;
    if (clr) begin
      q_d = 8'h00;
    end else if (inc && q_q != 8'h99) begin
      if (q_q[3:0] == 4'd9) q_d = {q_q[7:4] + 4'd1, 4'd0};
      else                  q_d = {q_q[7:4], q_q[3:0] + 4'd1};
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) q_q <= 8'h00;
    else       q_q <= q_d;
  end

  assign q = q_q;

endmodule

// File: rtl/pong_game_ctrl.sv
// Pong game-flow controller. Watches ball and paddle each frame, counts
// paddle hits into a BCD score, counts misses against lives and holds the
// ball block in reset while idle, during the post-miss pause and at game over.
//   clk, rstn          : clock, async active-low reset
//   refr_tick          : one-cycle frame pulse; game events sampled only here
//   btn_start          : raw start button (asynchronous)
//   ball_x/y, paddle_x/y : positions (left/top edges)
//   ball_rstn          : active-low reset to ball block (high only in PLAY)
//   score_bcd, lives   : score {tens,ones} and remaining lives
//   game_state         : current state, game_over high in OVER
//   hit_pulse          : one clk per counted paddle hit
module pong_game_ctrl #(
  parameter int BALL_SIZE   = pong_pkg::BALL_SIZE,
  parameter int PADDLE_W    = pong_pkg::PADDLE_W,
  parameter int PADDLE_H    = pong_pkg::PADDLE_H,
  parameter int MISS_X      = 630,
  parameter int MISS_X_MAX  = 700,
  parameter int LIVES_INIT  = 3,
  parameter int HOLD_FRAMES = 60
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       refr_tick,
  input  logic       btn_start,
  input  logic [9:0] ball_x,
  input  logic [9:0] ball_y,
  input  logic [9:0] paddle_x,
  input  logic [9:0] paddle_y,
  output logic       ball_rstn,
  output logic [7:0] score_bcd,
  output logic [1:0] lives,
  output logic [1:0] game_state,
  output logic       game_over,
  output logic       hit_pulse
);
  import pong_pkg::*;

  localparam int HW = $clog2(HOLD_FRAMES + 1);

  state_e          state_q, state_d;
  logic [1:0]      lives_q, lives_d;
  logic [HW-1:0]   hold_q, hold_d;
  logic            ovl_prev_q, ovl_prev_d;
  logic            hit_q, hit_d;
  logic            ball_rstn_q, ball_rstn_d;
  logic            game_over_q, game_over_d;
  logic            sync1_q, sync2_q, sync3_q;
  logic            start_evt, ovl, miss, score_clr, score_inc;

  // sync3_q is the previous synchronized level, used for edge detection
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      sync3_q <= 1'b0;
    end else begin
      sync1_q <= btn_start;
      sync2_q <= sync1_q;
      sync3_q <= sync2_q;
    end
  end

  assign start_evt = sync2_q & ~sync3_q;

  // 11-bit sums so ball/paddle near 1023 cannot wrap into a false overlap
  assign ovl = ({1'b0, ball_x} + 11'(BALL_SIZE) >= {1'b0, paddle_x}) &&
               ({1'b0, ball_x} <= {1'b0, paddle_x} + 11'(PADDLE_W)) &&
               ({1'b0, ball_y} + 11'(BALL_SIZE) >= {1'b0, paddle_y}) &&
               ({1'b0, ball_y} <= {1'b0, paddle_y} + 11'(PADDLE_H));

  // Upper bound rejects the ball block's left-edge wrap values (e.g. 1022)
  assign miss = (ball_x >= 10'(MISS_X)) && (ball_x < 10'(MISS_X_MAX));

  always_comb begin
    state_d    = state_q;
    lives_d    = lives_q;
    hold_d     = hold_q;
    ovl_prev_d = ovl_prev_q;
    hit_d      = 1'b0;
    score_clr  = 1'b0;
    score_inc  = 1'b0;
    case (state_q)
      ST_IDLE, ST_OVER: begin
        if (start_evt) begin
          score_clr  = 1'b1;
          lives_d    = 2'(LIVES_INIT);
          ovl_prev_d = 1'b0;
          state_d    = ST_PLAY;
        end
      end
      ST_PLAY: begin
        if (refr_tick) begin
          ovl_prev_d = ovl;
          if (miss) begin
            lives_d = (lives_q != 2'd0) ? lives_q - 2'd1 : 2'd0;
            hold_d  = '0;
            state_d = ST_MISS;
          end else if (ovl && !ovl_prev_q) begin
            score_inc = 1'b1;
            hit_d     = 1'b1;
          end
        end
      end
      ST_MISS: begin
        if (refr_tick) begin
          if (hold_q == HW'(HOLD_FRAMES - 1)) begin
            ovl_prev_d = 1'b0;
            state_d    = (lives_q == 2'd0) ? ST_OVER : ST_PLAY;
          end else begin
            hold_d = hold_q + 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // Outputs follow the next state so they change on the transition edge
    ball_rstn_d = (state_d == ST_PLAY);
    game_over_d = (state_d == ST_OVER);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= ST_IDLE;
      lives_q     <= 2'(LIVES_INIT);
      hold_q      <= '0;
      ovl_prev_q  <= 1'b0;
      hit_q       <= 1'b0;
      ball_rstn_q <= 1'b0;
      game_over_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      lives_q     <= lives_d;
      hold_q      <= hold_d;
      ovl_prev_q  <= ovl_prev_d;
      hit_q       <= hit_d;
      ball_rstn_q <= ball_rstn_d;
      game_over_q <= game_over_d;
    end
  end

  bcd2_sat_counter u_score (
    .clk  (clk),
    .rstn (rstn),
    .clr  (score_clr),
    .inc  (score_inc),
    .q    (score_bcd)
  );

  assign ball_rstn  = ball_rstn_q;
  assign lives      = lives_q;
  assign game_state = state_q;
  assign game_over  = game_over_q;
  assign hit_pulse  = hit_q;

endmodule

// File: tb/tb_pong_game_ctrl.sv
module tb_pong_game_ctrl;

  logic       clk = 1'b0;
  logic       rstn;
  logic       refr_tick;
  logic       btn_start;
  logic [9:0] ball_x, ball_y, paddle_x, paddle_y;
  logic       ball_rstn;
  logic [7:0] score_bcd;
  logic [1:0] lives;
  logic [1:0] game_state;
  logic       game_over;
  logic       hit_pulse;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  pong_game_ctrl dut (
    .clk        (clk),
    .rstn       (rstn),
    .refr_tick  (refr_tick),
    .btn_start  (btn_start),
    .ball_x     (ball_x),
    .ball_y     (ball_y),
    .paddle_x   (paddle_x),
    .paddle_y   (paddle_y),
    .ball_rstn  (ball_rstn),
    .score_bcd  (score_bcd),
    .lives      (lives),
    .game_state (game_state),
    .game_over  (game_over),
    .hit_pulse  (hit_pulse)
  );

  task automatic chk(input string tag, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", tag, act, exp);
    end
  endtask

  // One frame pulse; returns on the falling edge after the tick was taken
  task automatic tick();
    @(negedge clk) refr_tick = 1'b1;
    @(negedge clk) refr_tick = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic set_ball(input int x, input int y);
    ball_x = 10'(x);
    ball_y = 10'(y);
  endtask

  // Non-overlapping frame then overlapping frame against paddle (600,200)
  task automatic hit();
    set_ball(100, 100);
    tick();
    set_ball(592, 250);
    tick();
  endtask

  task automatic press();
    @(negedge clk) btn_start = 1'b1;
    repeat (5) @(negedge clk);
    btn_start = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_state"}, game_state, 0);
    chk({tag, "_brstn"}, ball_rstn, 0);
    chk({tag, "_score"}, score_bcd, 8'h00);
    chk({tag, "_lives"}, lives, 3);
    chk({tag, "_over"},  game_over, 0);
    chk({tag, "_hit"},   hit_pulse, 0);
  endtask

  initial begin
    int n;
    rstn = 1'b0; refr_tick = 1'b0; btn_start = 1'b0;
    set_ball(100, 100);
    paddle_x = 10'd600; paddle_y = 10'd200;
    #12;
    chk_reset("rst");
    @(negedge clk) rstn = 1'b1;

    // start latency: raw edge between edges, PLAY within 3..4 posedges
    @(negedge clk) btn_start = 1'b1;
    n = 0;
    for (int i = 1; i <= 10; i++) begin
      @(posedge clk); #1;
      if (game_state == 2'd1) begin n = i; break; end
    end
    chk("start_lat_ok", (n >= 3 && n <= 4) ? 1 : 0, 1);
    chk("start_brstn", ball_rstn, 1);
    btn_start = 1'b0;
    repeat (3) @(negedge clk);

    // first hit, then overlap held
    tick();
    set_ball(592, 250);
    tick();
    chk("hit1_pulse", hit_pulse, 1);
    chk("hit1_score", score_bcd, 8'h01);
    @(negedge clk);
    chk("hit1_pulse_off", hit_pulse, 0);
    ticks(5);
    chk("held_score", score_bcd, 8'h01);

    // BCD carry 09 -> 10
    for (int i = 0; i < 8; i++) hit();
    chk("score_09", score_bcd, 8'h09);
    hit();
    chk("score_10", score_bcd, 8'h10);

    // left-edge wrap is not a miss
    set_ball(1022, 250);
    tick();
    chk("wrap_state", game_state, 1);
    chk("wrap_lives", lives, 3);

    // first miss and 60-tick hold
    set_ball(632, 100);
    tick();
    chk("miss1_lives", lives, 2);
    chk("miss1_state", game_state, 2);
    chk("miss1_brstn", ball_rstn, 0);
    set_ball(100, 100);
    ticks(59);
    chk("hold59_state", game_state, 2);
    tick();
    chk("hold60_state", game_state, 1);
    chk("hold60_brstn", ball_rstn, 1);

    // miss and overlap on the same tick: miss wins
    tick();
    paddle_x = 10'd630;
    set_ball(635, 250);
    @(negedge clk) refr_tick = 1'b1;
    @(negedge clk) refr_tick = 1'b0;
    chk("simul_hit", hit_pulse, 0);
    chk("simul_score", score_bcd, 8'h10);
    chk("simul_lives", lives, 1);
    chk("simul_state", game_state, 2);
    paddle_x = 10'd600;
    set_ball(100, 100);
    ticks(60);
    chk("back_play", game_state, 1);

    // saturation at 99
    for (int i = 0; i < 89; i++) hit();
    chk("score_99", score_bcd, 8'h99);
    set_ball(100, 100);
    tick();
    set_ball(592, 250);
    tick();
    chk("sat_pulse", hit_pulse, 1);
    chk("sat_score", score_bcd, 8'h99);

    // third miss -> OVER after the hold
    set_ball(640, 100);
    tick();
    chk("miss3_lives", lives, 0);
    set_ball(592, 250);
    ticks(60);
    chk("over_state", game_state, 3);
    chk("over_flag", game_over, 1);
    chk("over_brstn", ball_rstn, 0);
    hit();
    chk("over_frozen", score_bcd, 8'h99);

    // restart from OVER
    press();
    chk("restart_state", game_state, 1);
    chk("restart_score", score_bcd, 8'h00);
    chk("restart_lives", lives, 3);
    chk("restart_over", game_over, 0);

    // async reset mid-hold
    set_ball(650, 100);
    tick();
    set_ball(100, 100);
    ticks(10);
    chk("midhold_state", game_state, 2);
    #2 rstn = 1'b0;
    #1;
    chk_reset("arst");
    @(negedge clk) rstn = 1'b1;
    ticks(3);
    chk("post_rst_state", game_state, 0);
    chk("post_rst_brstn", ball_rstn, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
